// File: rtl/calc_stack_pkg.sv
// Shared types and defaults for the calculator stack data path.
package calc_stack_pkg;

  localparam int          DW_DEF   = 16;
  localparam int          AW_DEF   = 9;
  localparam logic [15:0] SP_RESET = 16'h01FF;

  typedef enum logic {
    IDLE   = 1'b0,
    POP_RD = 1'b1
  } state_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x DW, one synchronous write port and one
// synchronous read port with a registered output.
module stack_ram #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rdata;

  // Write on request. A write and a read on the same edge never share an
  // address in this design: a read follows its write by at least one edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read, data valid in the cycle after the request
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_unit.sv
// Calculator hardware stack: FSM, stack pointer, entry counter, flags and
// the pop data register. The stack grows downward from SP_TOP.
// Optional macro STACK_ERR_STICKY_EN: OVF/UDF latch until reset and freeze
// the unit; when undefined they are single-cycle pulses.
module stack_unit
  import calc_stack_pkg::*;
#(
  parameter int          DW     = DW_DEF,
  parameter int          AW     = AW_DEF,
  parameter logic [15:0] SP_TOP = SP_RESET
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic          o_ready,
  output logic          o_ack,
  output logic [DW-1:0] o_dout,
  output logic          o_dvalid,
  output logic          o_ovf,
  output logic          o_udf,
  output logic          o_full,
  output logic          o_empty,
  output logic [15:0]   o_sp
);

  localparam int        DEPTH      = 2**AW;
  localparam logic [AW:0] COUNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0] COUNT_ONE  = 1;

  state_t        r_state;
  logic [15:0]   r_sp;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic          r_ack;
  logic          r_dvalid;
  logic          r_ovf;
  logic          r_udf;

  logic          w_ready;
  logic          w_full;
  logic          w_empty;
  logic          w_push_acc;
  logic          w_pop_acc;
  logic          w_do_push;
  logic          w_do_pop;
  logic [15:0]   w_sp_inc;
  logic [DW-1:0] w_rdata;

  assign w_full  = (r_count == COUNT_FULL);
  assign w_empty = (r_count == '0);

`ifdef STACK_ERR_STICKY_EN
  assign w_ready = (r_state == IDLE) && !(r_ovf || r_udf);
`else
  assign w_ready = (r_state == IDLE);
`endif

  // PUSH has priority; a simultaneous POP is dropped.
  assign w_push_acc = w_ready && i_push;
  assign w_pop_acc  = w_ready && i_pop && !i_push;
  assign w_do_push  = w_push_acc && !w_full;
  assign w_do_pop   = w_pop_acc && !w_empty;
  assign w_sp_inc   = r_sp + 16'd1;

  // The RAM read is launched on the pop accept edge so the word is ready
  // during POP_RD; a push on the previous edge has already committed.
  stack_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_do_push),
    .i_waddr (r_sp[AW-1:0]),
    .i_wdata (i_din),
    .i_re    (w_do_pop),
    .i_raddr (w_sp_inc[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Control FSM with SP, COUNT, DOUT and the status pulses/flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_sp     <= SP_TOP;
      r_count  <= '0;
      r_dout   <= '0;
      r_ack    <= 1'b0;
      r_dvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ack    <= 1'b0;
      r_dvalid <= 1'b0;
`ifdef STACK_ERR_STICKY_EN
      if (w_push_acc && w_full)  r_ovf <= 1'b1;
      if (w_pop_acc  && w_empty) r_udf <= 1'b1;
`else
      r_ovf <= w_push_acc && w_full;
      r_udf <= w_pop_acc && w_empty;
`endif
      case (r_state)
        IDLE: begin
          if (w_do_push) begin
            r_sp    <= r_sp - 16'd1;
            r_count <= r_count + COUNT_ONE;
            r_ack   <= 1'b1;
          end else if (w_do_pop) begin
            r_sp    <= w_sp_inc;
            r_count <= r_count - COUNT_ONE;
            r_state <= POP_RD;
          end
        end
        POP_RD: begin
          r_dout   <= w_rdata;
          r_dvalid <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready  = w_ready;
  assign o_ack    = r_ack;
  assign o_dout   = r_dout;
  assign o_dvalid = r_dvalid;
  assign o_ovf    = r_ovf;
  assign o_udf    = r_udf;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_sp     = r_sp;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expectations.
module tb_stack_unit;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic        pop;
  logic [15:0] din;
  logic        ready;
  logic        ack;
  logic [15:0] dout;
  logic        dvalid;
  logic        ovf;
  logic        udf;
  logic        full;
  logic        empty;
  logic [15:0] sp;

  int n_checks;
  int n_errors;

  stack_unit dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_push   (push),
    .i_pop    (pop),
    .i_din    (din),
    .o_ready  (ready),
    .o_ack    (ack),
    .o_dout   (dout),
    .o_dvalid (dvalid),
    .o_ovf    (ovf),
    .o_udf    (udf),
    .o_full   (full),
    .o_empty  (empty),
    .o_sp     (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [15:0] d, input string tag);
    push = 1'b1;
    din  = d;
    tick();
    push = 1'b0;
    check({tag, " ack"}, {31'd0, ack}, 32'd1);
  endtask

  task automatic do_pop(input logic [15:0] exp, input string tag);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check({tag, " ready in POP_RD"}, {31'd0, ready}, 32'd0);
    tick();
    check({tag, " dvalid"}, {31'd0, dvalid}, 32'd1);
    check({tag, " dout"}, {16'd0, dout}, {16'd0, exp});
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst sp", {16'd0, sp}, 32'h01FF);
    check("rst empty", {31'd0, empty}, 32'd1);
    check("rst full", {31'd0, full}, 32'd0);
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst pulses", {28'd0, ack, dvalid, ovf, udf}, 32'd0);
    check("rst dout", {16'd0, dout}, 32'd0);

    // Two pushes then two pops, LIFO order
    do_push(16'h1234, "push1");
    check("push1 sp", {16'd0, sp}, 32'h01FE);
    do_push(16'hABCD, "push2");
    check("push2 sp", {16'd0, sp}, 32'h01FD);
    tick();
    check("ack drops", {31'd0, ack}, 32'd0);
    do_pop(16'hABCD, "pop1");
    check("pop1 sp", {16'd0, sp}, 32'h01FE);
    tick();
    check("dvalid drops", {31'd0, dvalid}, 32'd0);
    do_pop(16'h1234, "pop2");
    check("pop2 sp", {16'd0, sp}, 32'h01FF);
    check("pop2 empty", {31'd0, empty}, 32'd1);

    // Pop on empty stack
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("udf pulse", {31'd0, udf}, 32'd1);
    check("udf sp", {16'd0, sp}, 32'h01FF);
    tick();
    check("udf dvalid", {31'd0, dvalid}, 32'd0);
    check("udf dout held", {16'd0, dout}, 32'h1234);
`ifdef STACK_ERR_STICKY_EN
    check("udf sticky", {31'd0, udf}, 32'd1);
    check("udf frozen ready", {31'd0, ready}, 32'd0);
`else
    check("udf cleared", {31'd0, udf}, 32'd0);
    check("udf ready", {31'd0, ready}, 32'd1);
`endif

    // Asynchronous reset in the middle of a run
    apply_reset();
    do_push(16'h5555, "push pre-rst");
    #2 rst_n = 1'b0;
    #1;
    check("async rst sp", {16'd0, sp}, 32'h01FF);
    check("async rst empty/full/ready", {29'd0, empty, full, ready}, 32'b101);
    check("async rst pulses", {28'd0, ack, dvalid, ovf, udf}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Fill to 512 entries with back-to-back pushes
    acks = 0;
    push = 1'b1;
    for (int k = 0; k < 512; k++) begin
      din = 16'hC000 ^ 16'(k);
      tick();
      if (ack) acks++;
    end
    push = 1'b0;
    check("fill acks", 32'(acks), 32'd512);
    check("fill full", {31'd0, full}, 32'd1);
    check("fill sp", {16'd0, sp}, 32'h0000FFFF);
    tick();
    push = 1'b1;
    din  = 16'hDEAD;
    tick();
    push = 1'b0;
    check("ovf pulse", {31'd0, ovf}, 32'd1);
    check("ovf no ack", {31'd0, ack}, 32'd0);
    check("ovf sp", {16'd0, sp}, 32'h0000FFFF);
`ifdef STACK_ERR_STICKY_EN
    tick();
    check("ovf sticky", {31'd0, ovf}, 32'd1);
    check("ovf frozen ready", {31'd0, ready}, 32'd0);
`else
    tick();
    check("ovf cleared", {31'd0, ovf}, 32'd0);
    do_pop(16'hC1FF, "pop full");
    check("pop full sp", {16'd0, sp}, 32'h0000);
    check("pop full not full", {31'd0, full}, 32'd0);
`endif
    apply_reset();

    // PUSH and POP together: push wins
    do_push(16'h0777, "push c1");
    push = 1'b1;
    pop  = 1'b1;
    din  = 16'h0888;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    check("both ack", {31'd0, ack}, 32'd1);
    check("both sp", {16'd0, sp}, 32'h01FD);
    check("both ready", {31'd0, ready}, 32'd1);
    tick();
    check("both no dvalid", {31'd0, dvalid}, 32'd0);
    do_pop(16'h0888, "pop after both");

    // Reset during POP_RD aborts the pop
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("abort in POP_RD", {31'd0, ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort ready", {31'd0, ready}, 32'd1);
    check("abort sp", {16'd0, sp}, 32'h01FF);
    tick();
    check("abort no dvalid", {31'd0, dvalid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort post dvalid", {31'd0, dvalid}, 32'd0);
    check("abort post empty", {31'd0, empty}, 32'd1);
    check("abort post dout", {16'd0, dout}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
